// File: rtl/ccsds_iq_axis_packer.sv
// IQ-sample to AXI4-Stream packer: circular FIFO, tagged I/Q lanes, framed TLAST.
// Optional start-of-frame TUSER output enabled by defining CCSDS_TX_SOF_TUSER_EN.
module ccsds_iq_axis_packer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH         = 13,
  parameter int FIFO_DEPTH           = 16,
  parameter int FRAME_LEN            = 256
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic [SAMPLE_WIDTH-1:0]             i_data_i,
  input  logic [SAMPLE_WIDTH-1:0]             q_data_i,
  input  logic                                valid_i,
  input  logic                                clear_ovf_i,
  output logic                                overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
`ifdef CCSDS_TX_SOF_TUSER_EN
  output logic [0:0]                          M_AXIS_TUSER,
`endif
  input  logic                                M_AXIS_TREADY
);

  localparam int W     = C_M_AXIS_TDATA_WIDTH;
  localparam int H     = W / 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int ENT_W = 2 * SAMPLE_WIDTH;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [W-1:0]     tdata_q;
  logic             tvalid_q;
  logic [CNT_W-1:0] beat_cnt;
  logic             ovf_q;

  logic empty, full, pop, push, accept, last_beat;
  logic [ENT_W-1:0] rd_entry;

  // Each lane: 2-bit tag, sample, then zero pad down to the lane LSB.
  function automatic logic [W-1:0] pack_beat(input logic [SAMPLE_WIDTH-1:0] i_s,
                                             input logic [SAMPLE_WIDTH-1:0] q_s);
    logic [H-1:0] i_lane;
    logic [H-1:0] q_lane;
    i_lane = '0;
    q_lane = '0;
    i_lane[H-1 -: 2]            = 2'b10;
    i_lane[H-3 -: SAMPLE_WIDTH] = i_s;
    q_lane[H-1 -: 2]            = 2'b01;
    q_lane[H-3 -: SAMPLE_WIDTH] = q_s;
    return {i_lane, q_lane};
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign accept    = tvalid_q && M_AXIS_TREADY;
  assign pop       = !empty && (!tvalid_q || M_AXIS_TREADY);
  assign push      = valid_i && (!full || pop);
  assign rd_entry  = mem[rd_ptr[PTR_W-1:0]];
  assign last_beat = (beat_cnt == CNT_W'(FRAME_LEN - 1));

  // NOTE: sample storage is deliberately left out of reset; the pointers alone
  // define which entries are live, and a reset-free array maps onto RAM.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {i_data_i, q_data_i};
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the same pre-edge values of push/pop/accept.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      beat_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);

      if (pop) begin
        tdata_q  <= pack_beat(rd_entry[ENT_W-1 -: SAMPLE_WIDTH],
                              rd_entry[SAMPLE_WIDTH-1:0]);
        tvalid_q <= 1'b1;
      end else if (accept) begin
        tdata_q  <= '0;
        tvalid_q <= 1'b0;
      end

      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;

      // A drop in the same cycle as a clear request keeps the flag set.
      if (valid_i && full && !pop) ovf_q <= 1'b1;
      else if (clear_ovf_i)        ovf_q <= 1'b0;
    end
  end

  assign overflow_o    = ovf_q;
  assign fifo_level_o  = level_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TSTRB  = {(W/8){tvalid_q}};
  assign M_AXIS_TLAST  = tvalid_q && last_beat;
`ifdef CCSDS_TX_SOF_TUSER_EN
  assign M_AXIS_TUSER  = tvalid_q && (beat_cnt == '0);
`endif

endmodule

// File: tb/tb_ccsds_iq_axis_packer.sv
// Self-checking bench for ccsds_iq_axis_packer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ccsds_iq_axis_packer;

  localparam int W  = 32;
  localparam int SW = 13;
  localparam int D  = 16;
  localparam int FL = 4;
  localparam int H  = W / 2;
  localparam int PAD = H - 2 - SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] i_s = '0, q_s = '0;
  logic          valid = 1'b0, clr = 1'b0, tready = 1'b0;
  logic          ovf;
  logic [4:0]    level;
  logic          tvalid, tlast;
  logic [W-1:0]  tdata;
  logic [3:0]    tstrb;
`ifdef CCSDS_TX_SOF_TUSER_EN
  logic [0:0]    tuser;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ccsds_iq_axis_packer #(
    .C_M_AXIS_TDATA_WIDTH(W), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(D), .FRAME_LEN(FL)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
    .i_data_i(i_s), .q_data_i(q_s), .valid_i(valid), .clear_ovf_i(clr),
    .overflow_o(ovf), .fifo_level_o(level),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast),
`ifdef CCSDS_TX_SOF_TUSER_EN
    .M_AXIS_TUSER(tuser),
`endif
    .M_AXIS_TREADY(tready)
  );

  // Lane = (tag * 2^SW + sample) * 2^PAD, computed arithmetically.
  function automatic logic [W-1:0] ref_pack(input int i, input int q);
    int unsigned il, ql;
    il = ((2 << SW) + i) << PAD;
    ql = ((1 << SW) + q) << PAD;
    return W'((il << H) | ql);
  endfunction

  function automatic logic [SW-1:0] smp_i(input int s); return SW'(s * 37 + 5); endfunction
  function automatic logic [SW-1:0] smp_q(input int s); return SW'(8191 - s * 3); endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sample queue plus one output slot, beats counted modulo FL.
  logic [W-1:0] m_q[$];
  logic         m_ov = 1'b0;
  logic [W-1:0] m_out = '0;
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); m_ov = 1'b0; m_out = '0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      bit m_pop, m_full, m_push, m_acc;
      m_full = (m_q.size() == D);
      m_acc  = m_ov && tready;
      m_pop  = (m_q.size() > 0) && (!m_ov || tready);
      m_push = valid && (!m_full || m_pop);
      if (m_acc) m_cnt = (m_cnt + 1) % FL;
      if (valid && m_full && !m_pop) m_ovf = 1'b1;
      else if (clr)                  m_ovf = 1'b0;
      if (m_pop) begin
        m_out = m_q.pop_front(); m_ov = 1'b1;
      end else if (m_acc) begin
        m_out = '0; m_ov = 1'b0;
      end
      if (m_push) m_q.push_back(ref_pack(int'(i_s), int'(q_s)));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_last, exp_user, bad;
      exp_last = m_ov && (m_cnt == FL - 1);
      exp_user = m_ov && (m_cnt == 0);
      bad = (tvalid !== m_ov) || (tdata !== m_out) || (tlast !== exp_last) ||
            (tstrb !== {4{m_ov}}) || (int'(level) != m_q.size()) || (ovf !== m_ovf);
`ifdef CCSDS_TX_SOF_TUSER_EN
      bad = bad || (tuser[0] !== exp_user);
`endif
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL model @%0t: got v=%0b d=%h l=%0b s=%h lvl=%0d o=%0b, expected v=%0b d=%h l=%0b lvl=%0d o=%0b u=%0b",
                 $time, tvalid, tdata, tlast, tstrb, level, ovf,
                 m_ov, m_out, exp_last, m_q.size(), m_ovf, exp_user);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0; tready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int s = 0; s < n; s++) begin
      valid = 1'b1; i_s = smp_i(base + s); q_s = smp_q(base + s);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    tready = 1'b1; valid = 1'b0;
    for (c = 0; c < 64 && (tvalid || level != 0); c++) @(negedge clk);
    check("drain_empty", {tvalid, level}, 6'd0);
  endtask

  // Walks n beats, checking frame markers each cycle including stalls.
  task automatic run_frame(input int n, input bit rnd_ready);
    int idx = 0;
    for (int c = 0; c < 400 && idx < n; c++) begin
      tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid) begin
        check("tlast", tlast, (idx % FL) == FL - 1);
`ifdef CCSDS_TX_SOF_TUSER_EN
        check("tuser_sof", tuser, (idx % FL) == 0);
`endif
        if (tready) idx++;
      end
      @(negedge clk);
    end
    check("frame_beats", idx, n);
  endtask

  typedef struct {
    logic [SW-1:0] i;
    logic [SW-1:0] q;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{13'h0ABC, 13'h1555, 32'h95786AAA};
    vecs[1] = '{13'h0000, 13'h0000, 32'h80004000};
    vecs[2] = '{13'h1FFF, 13'h1FFF, 32'hBFFE7FFE};
    vecs[3] = '{13'h0001, 13'h1000, 32'h80026000};

    #1;
    check("rst_outputs", {tvalid, tdata, tstrb, tlast, level, ovf}, '0);
    do_reset();

    // Packing and latency, one sample at a time.
    foreach (vecs[k]) begin
      tready = 1'b1; valid = 1'b1; i_s = vecs[k].i; q_s = vecs[k].q;
      @(negedge clk);
      valid = 1'b0;
      check("lat_k", tvalid, 1'b0);
      @(negedge clk);
      check("lat_k1_valid", tvalid, 1'b1);
      check("pack_tdata", tdata, vecs[k].exp);
      check("tstrb_on", tstrb, 4'hF);
      @(negedge clk);
      check("idle_tdata", {tvalid, tdata}, '0);
    end

    // Overflow: 18 samples under backpressure, 17 retained.
    do_reset();
    tready = 1'b0;
    push_n(18, 1);
    check("ovf_level", level, 5'd16);
    check("ovf_set", ovf, 1'b1);
    check("frozen_tdata", tdata, ref_pack(int'(smp_i(1)), int'(smp_q(1))));
    tready = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      check("order_valid", tvalid, 1'b1);
      check("order_tdata", tdata, ref_pack(int'(smp_i(j)), int'(smp_q(j))));
      @(negedge clk);
    end
    check("order_done", tvalid, 1'b0);
    check("ovf_sticky", ovf, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    tready = 1'b0;
    push_n(17, 40);
    check("full_level", level, 5'd16);
    valid = 1'b1; tready = 1'b1; i_s = 13'h0123; q_s = 13'h0456;
    @(negedge clk);
    valid = 1'b0; tready = 1'b0;
    check("full_pp_level", level, 5'd16);
    check("full_pp_ovf", ovf, 1'b0);
    drain();

    // Framing under random stalls.
    do_reset();
    tready = 1'b0;
    push_n(10, 100);
    run_frame(10, 1'b1);
    drain();

    // Asynchronous reset mid-frame.
    do_reset();
    tready = 1'b1;
    push_n(2, 200);
    repeat (3) @(negedge clk);
    tready = 1'b0;
    push_n(3, 210);
    check("pre_rst_valid", tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {tvalid, tlast, tdata, level}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    push_n(4, 220);
    run_frame(4, 1'b0);
    drain();

`ifdef CCSDS_TX_SOF_TUSER_EN
    do_reset();
    tready = 1'b0;
    push_n(8, 300);
    run_frame(8, 1'b0);
    drain();
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      valid  = ($urandom_range(0, 3) != 0);
      i_s    = SW'($urandom);
      q_s    = SW'($urandom);
      tready = (c < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    clr = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
